cam_capture_ctrl: RTL
=====================

CAM_CAPTURE_CTRL -- requirements
Module: cam_capture_ctrl

Interface
REQ-001 Parameter H_ACTIVE, default 1280: pixels per active line; each pixel is 2 bytes (RGB565).
REQ-002 Parameter V_ACTIVE, default 720: active lines per frame.
REQ-003 i_pclk  in  1  sensor pixel clock; all logic is on its rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_init_done  in  1  sensor-configuration-complete level from the 100MHz domain; asynchronous to i_pclk.
REQ-006 i_enable  in  1  capture arm level, i_pclk domain.
REQ-007 i_vsync, i_href  in  1 each  sensor sync inputs; vsync high marks vertical blanking.
REQ-008 i_fifo_full  in  1  pixel FIFO write-side full.
REQ-009 o_byte_en  out  1  qualifies i_pdata bytes into the 8-to-16 packer.
REQ-010 o_sof, o_eol, o_eof  out  1 each  single-cycle start-of-frame, end-of-good-line, end-of-good-frame pulses.
REQ-011 o_line_toggle  out  1  flips once per good line; for CDC to the HDMI domain.
REQ-012 o_line_cnt  out  11  good lines captured in the current frame.
REQ-013 o_err_len  out  1  single-cycle pulse on a line/frame length mismatch.
REQ-014 o_err_ovf  out  1  sticky overflow flag.
REQ-015 o_state  out  3  current FSM state encoding.

Function
REQ-016 i_init_done SHALL pass through a 2-flop synchronizer (init_s) before use.
REQ-017 vsync SHALL be registered once (vsync_q):
- vs_rise = i_vsync & !vsync_q
- vs_fall = !i_vsync & vsync_q
REQ-018 href SHALL be registered once (href_q); hs_fall = !i_href & href_q.
REQ-019 The FSM SHALL have these states and encodings: IDLE=0, SYNC=1, ACTIVE=2, DROP=3.
REQ-020 IDLE -> SYNC SHALL occur when init_s & i_enable.
REQ-021 SYNC -> ACTIVE SHALL occur on vs_fall, which aligns capture to the first line of a frame; o_sof pulses the same cycle.
REQ-022 In ACTIVE, on vs_rise:
- o_eof pulses if o_line_cnt==V_ACTIVE, else o_err_len pulses.
- Next state is SYNC if i_enable, else IDLE.
REQ-023 ACTIVE -> DROP SHALL occur when i_href & i_fifo_full.
- o_err_ovf sets that cycle.
- The byte is not accepted.
REQ-024 DROP -> SYNC (or IDLE if !i_enable) SHALL occur on vs_rise; no o_eof in DROP.
REQ-025 Any state SHALL go to IDLE within one cycle of init_s=0.
REQ-026 o_byte_en SHALL be combinational: (state==ACTIVE) & i_href & !i_fifo_full, so the first href byte is accepted with zero latency.
REQ-027 Byte counter, 12 bits:
- Increments on o_byte_en.
- Clears on hs_fall and on entry to ACTIVE.
- Saturates at 4095.
REQ-028 On hs_fall in ACTIVE:
- If count==2*H_ACTIVE: o_eol pulses, o_line_toggle flips, o_line_cnt increments (saturating at 2047).
- Otherwise o_err_len pulses and o_line_cnt is unchanged.
REQ-029 o_line_cnt SHALL clear on the SYNC->ACTIVE transition.
REQ-030 If hs_fall and vs_rise coincide, the line check (REQ-028) SHALL apply first, and the frame check (REQ-022) SHALL use the updated count.
REQ-031 o_err_ovf SHALL clear only on reset, or on the IDLE->SYNC transition.
REQ-032 Deasserting i_enable mid-frame SHALL NOT truncate the frame; the controller finishes at the next vs_rise.
REQ-033 Every pulse output SHALL be exactly one i_pclk cycle wide and registered, except o_byte_en.

Reset
REQ-034 On i_rst, immediately and asynchronously:
- state=IDLE
- all outputs 0, including o_line_toggle, o_line_cnt and o_err_ovf
- synchronizer, vsync_q, href_q and counters cleared
REQ-035 Asserting i_rst mid-line SHALL deassert o_byte_en immediately.
REQ-036 After reset release, capture SHALL restart only via IDLE->SYNC->ACTIVE; a partial frame is never captured.

Verification (H_ACTIVE=4, V_ACTIVE=3)
REQ-037 Good frame:
- Stimulus: init_done=1, enable=1, vsync fall, 3 lines of 8 href bytes, vsync rise.
- Response: one o_sof, 3 o_eol, o_line_toggle toggles 3 times, o_line_cnt=3, one o_eof, no errors.
REQ-038 Short line:
- Stimulus: line 2 has 6 bytes.
- Response: o_err_len pulses at that href fall, o_line_cnt ends at 2, o_err_len pulses at vsync rise, no o_eof.
REQ-039 Overflow:
- Stimulus: i_fifo_full=1 during line 1, byte 3.
- Response: o_byte_en low from that cycle, state=DROP, o_err_ovf=1 sticky, no o_eol/o_eof until the next vsync rise, then SYNC.
REQ-040 Mid-frame start:
- Stimulus: enable rises while href is active.
- Response: o_byte_en stays 0 until after the next vsync fall, then a full good frame.
REQ-041 Disable mid-frame:
- Stimulus: enable drops during line 2.
- Response: lines 2 and 3 complete, o_eof pulses, state=IDLE, next frame ignored.
REQ-042 Reset mid-line:
- Stimulus: assert i_rst during line 1.
- Response: all outputs 0 asynchronously; after release, state=IDLE, then SYNC.

Source files
------------

// File: rtl/cam_capture_ctrl.sv
// cam_capture_ctrl
//   Camera capture front end. It aligns capture to the start of a sensor
//   frame and qualifies incoming RGB565 bytes into the 8-to-16 packer. It
//   also checks line and frame lengths and reports FIFO overflow.
//
// Ports
//   i_pclk        sensor pixel clock (rising edge)
//   i_rst         asynchronous active-high reset
//   i_init_done   sensor-config-done level, asynchronous (synchronized here)
//   i_enable      capture arm level
//   i_vsync       vertical sync (high = vertical blanking)
//   i_href        line-valid
//   i_fifo_full   pixel FIFO full
//   o_byte_en     combinational byte qualifier
//   o_sof/o_eol/o_eof  start-of-frame, end-of-good-line, end-of-good-frame pulses
//   o_line_toggle flips once per good line (for CDC)
//   o_line_cnt    good lines captured in the current frame
//   o_err_len     line/frame length mismatch pulse
//   o_err_ovf     sticky overflow flag
//   o_state       FSM state encoding
module cam_capture_ctrl #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 720
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic        i_init_done,
  input  logic        i_enable,
  input  logic        i_vsync,
  input  logic        i_href,
  input  logic        i_fifo_full,
  output logic        o_byte_en,
  output logic        o_sof,
  output logic        o_eol,
  output logic        o_eof,
  output logic        o_line_toggle,
  output logic [10:0] o_line_cnt,
  output logic        o_err_len,
  output logic        o_err_ovf,
  output logic [2:0]  o_state
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SYNC   = 3'd1,
    ACTIVE = 3'd2,
    DROP   = 3'd3
  } state_t;

  localparam logic [11:0] LINE_BYTES  = 12'(2 * H_ACTIVE);
  localparam logic [10:0] FRAME_LINES = 11'(V_ACTIVE);

  state_t      state, state_nxt;
  logic        init_m, init_s;
  logic        vsync_q, href_q;
  logic [11:0] byte_cnt, cnt_nxt;

  logic        vs_rise, vs_fall, hs_fall;
  logic        sof_nxt, eol_nxt, eof_nxt, err_nxt, tog_nxt, ovf_nxt;
  logic [10:0] lc_nxt;

  assign vs_rise = i_vsync & ~vsync_q;
  assign vs_fall = ~i_vsync & vsync_q;
  assign hs_fall = ~i_href & href_q;

  // State resets asynchronously, so this also drops immediately on i_rst.
  assign o_byte_en = (state == ACTIVE) & i_href & ~i_fifo_full;
  assign o_state   = state;

  always_comb begin
    state_nxt = state;
    sof_nxt   = 1'b0;
    eol_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    err_nxt   = 1'b0;
    tog_nxt   = o_line_toggle;
    lc_nxt    = o_line_cnt;
    ovf_nxt   = o_err_ovf;
    cnt_nxt   = byte_cnt;

    if (hs_fall) begin
      cnt_nxt = '0;
    end else if (o_byte_en && (byte_cnt != '1)) begin
      cnt_nxt = byte_cnt + 12'd1;
    end

    if (!init_s) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable) begin
            state_nxt = SYNC;
            ovf_nxt   = 1'b0;
          end
        end
        SYNC: begin
          if (vs_fall) begin
            state_nxt = ACTIVE;
            sof_nxt   = 1'b1;
            lc_nxt    = '0;
            cnt_nxt   = '0;
          end
        end
        ACTIVE: begin
          // Line check first; the frame check below sees its updated count.
          if (hs_fall) begin
            if (byte_cnt == LINE_BYTES) begin
              eol_nxt = 1'b1;
              tog_nxt = ~o_line_toggle;
              if (o_line_cnt != '1) begin
                lc_nxt = o_line_cnt + 11'd1;
              end
            end else begin
              err_nxt = 1'b1;
            end
          end
          if (vs_rise) begin
            if (lc_nxt == FRAME_LINES) begin
              eof_nxt = 1'b1;
            end else begin
              err_nxt = 1'b1;
            end
            state_nxt = i_enable ? SYNC : IDLE;
          end else if (i_href && i_fifo_full) begin
            state_nxt = DROP;
            ovf_nxt   = 1'b1;
          end
        end
        DROP: begin
          if (vs_rise) begin
            state_nxt = i_enable ? SYNC : IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_pclk or posedge i_rst) begin
    if (i_rst) begin
      state         <= IDLE;
      init_m        <= 1'b0;
      init_s        <= 1'b0;
      vsync_q       <= 1'b0;
      href_q        <= 1'b0;
      byte_cnt      <= '0;
      o_sof         <= 1'b0;
      o_eol         <= 1'b0;
      o_eof         <= 1'b0;
      o_err_len     <= 1'b0;
      o_line_toggle <= 1'b0;
      o_line_cnt    <= '0;
      o_err_ovf     <= 1'b0;
    end else begin
      state         <= state_nxt;
      init_m        <= i_init_done;
      init_s        <= init_m;
      vsync_q       <= i_vsync;
      href_q        <= i_href;
      byte_cnt      <= cnt_nxt;
      o_sof         <= sof_nxt;
      o_eol         <= eol_nxt;
      o_eof         <= eof_nxt;
      o_err_len     <= err_nxt;
      o_line_toggle <= tog_nxt;
      o_line_cnt    <= lc_nxt;
      o_err_ovf     <= ovf_nxt;
    end
  end

endmodule
